// File: rtl/lfsr_checker_4bit.sv
// Lock checker for an x^4+x^3+1 LFSR stream: HUNT -> VERIFY -> LOCKED with flywheel prediction.
// Optional saturating error counter is built only when LFSR_CHK_ERRCNT_EN is defined.
module lfsr_checker_4bit #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data_in,
    input  logic       data_valid,
    input  logic       err_clr,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_count
);
    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

    function automatic logic [3:0] lfsr_next(input logic [3:0] q);
        return {q[2:0], q[3] ^ q[2]};
    endfunction

    state_t     r_state;
    logic [3:0] r_pred;
    logic [3:0] r_match_cnt;
    logic [3:0] r_loss_cnt;
    logic       r_locked;
    logic       r_err;

    logic w_zero, w_hit, w_miss_locked;
    assign w_zero        = (data_in == 4'b0000);
    assign w_hit         = (data_in == r_pred);
    assign w_miss_locked = data_valid && (r_state == LOCKED) && !w_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= HUNT;
            r_pred      <= 4'b0000;
            r_match_cnt <= 4'd0;
            r_loss_cnt  <= 4'd0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (data_valid) begin
                case (r_state)
                    HUNT: begin
                        if (!w_zero) begin
                            r_pred      <= lfsr_next(data_in);
                            r_match_cnt <= 4'd0;
                            r_state     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (w_hit) begin
                            r_pred      <= lfsr_next(r_pred);
                            r_match_cnt <= r_match_cnt + 4'd1;
                            if (r_match_cnt + 4'd1 == LOCK_C) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else if (!w_zero) begin
                            r_pred      <= lfsr_next(data_in);
                            r_match_cnt <= 4'd0;
                        end else begin
                            r_state <= HUNT;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: the sample never reseeds the prediction while locked
                        r_pred <= lfsr_next(r_pred);
                        if (w_hit) begin
                            r_loss_cnt <= 4'd0;
                        end else begin
                            r_err <= 1'b1;
                            if (r_loss_cnt + 4'd1 == LOSS_C) begin
                                r_loss_cnt <= 4'd0;
                                r_state    <= HUNT;
                                r_locked   <= 1'b0;
                            end else begin
                                r_loss_cnt <= r_loss_cnt + 4'd1;
                            end
                        end
                    end
                    default: begin
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked = r_locked;
    assign err    = r_err;

`ifdef LFSR_CHK_ERRCNT_EN
    logic [7:0] r_err_count;

    // Clear beats a simultaneous error; count saturates at 255
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_count <= 8'h00;
        end else if (err_clr) begin
            r_err_count <= 8'h00;
        end else if (w_miss_locked && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'h01;
        end
    end

    assign err_count = r_err_count;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign err_count        = 8'h00;
`endif

endmodule

// File: tb/tb_lfsr_checker_4bit.sv
// Bench for lfsr_checker_4bit: directed steps plus random traffic against a phase-index model.
module tb_lfsr_checker_4bit;
    localparam int LOCK_N = 4;
    localparam int LOSS_N = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] data_in = 4'b0000;
    logic       data_valid = 1'b0;
    logic       err_clr = 1'b0;
    logic       locked, err;
    logic [7:0] err_count;

    lfsr_checker_4bit #(.LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .err_clr(err_clr), .locked(locked), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the legal sequence as a table, checker state as a phase index into it
    logic [3:0] seq [15];
    int m_mode, m_idx, m_cnt, m_loss, m_errs;
    bit m_locked, m_err;

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < 15; i++) if (seq[i] == v) return i;
        return 0;
    endfunction

    function automatic logic [7:0] cnt_exp(input int n);
`ifdef LFSR_CHK_ERRCNT_EN
        return (n > 255) ? 8'd255 : 8'(n);
`else
        return (n >= 0) ? 8'd0 : 8'd0;
`endif
    endfunction

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_cnt = 0; m_loss = 0; m_errs = 0;
        m_locked = 0; m_err = 0;
    endtask

    task automatic model_step(input bit v, input logic [3:0] d, input bit c);
        bit miss;
        logic [3:0] expv;
        miss = 0;
        expv = seq[(m_idx + 1) % 15];
        if (v) begin
            if (m_mode == 0) begin
                if (d != 0) begin m_idx = idx_of(d); m_cnt = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (d == expv) begin
                    m_idx = (m_idx + 1) % 15; m_cnt++;
                    if (m_cnt == LOCK_N) m_mode = 2;
                end else if (d != 0) begin
                    m_idx = idx_of(d); m_cnt = 0;
                end else m_mode = 0;
            end else begin
                m_idx = (m_idx + 1) % 15;
                if (d == expv) m_loss = 0;
                else begin
                    miss = 1; m_loss++;
                    if (m_loss == LOSS_N) begin m_mode = 0; m_loss = 0; end
                end
            end
        end
        m_err = miss;
        if (c) m_errs = 0;
        else if (miss && m_errs < 255) m_errs++;
        m_locked = (m_mode == 2);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input bit v, input logic [3:0] d, input bit c);
        data_valid = v; data_in = d; err_clr = c;
        @(posedge clk);
        model_step(v, d, c);
        #1;
        chk("locked", 8'(locked), 8'(m_locked));
        chk("err", 8'(err), 8'(m_err));
        chk("err_count", err_count, cnt_exp(m_errs));
    endtask

    task automatic feed_lock();
        cyc(1, 4'b0001, 0); cyc(1, 4'b0010, 0); cyc(1, 4'b0100, 0);
        cyc(1, 4'b1001, 0); cyc(1, 4'b0011, 0);
    endtask

    initial begin
        logic [3:0] v, good;
        int tx;
        v = 4'b0001;
        for (int i = 0; i < 15; i++) begin seq[i] = v; v = {v[2:0], v[3] ^ v[2]}; end
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_locked", 8'(locked), 8'd0);
        chk("rst_err", 8'(err), 8'd0);
        chk("rst_cnt", err_count, 8'd0);
        rst = 1'b1;
        @(negedge clk);

        // Acquire lock with continuous valid data
        feed_lock();
        chk("lock_basic", 8'(locked), 8'd1);

        // Single error while locked, flywheel continues on 1101, 1010
        cyc(1, 4'b1111, 0);
        chk("single_err_pulse", 8'(err), 8'd1);
        cyc(1, 4'b1101, 0);
        cyc(1, 4'b1010, 0);
        chk("single_still_locked", 8'(locked), 8'd1);
        chk("single_cnt", err_count, cnt_exp(1));

        // Loss of lock after three wrong samples
        cyc(1, 4'b0000, 0); cyc(1, 4'b0000, 0);
        chk("loss_not_yet", 8'(locked), 8'd1);
        cyc(1, 4'b0000, 0);
        chk("loss_unlocked", 8'(locked), 8'd0);
        chk("loss_cnt", err_count, cnt_exp(4));

        // Reacquire; count persists. Then clear on the same edge as an error.
        feed_lock();
        chk("relock_cnt_kept", err_count, cnt_exp(4));
        cyc(1, 4'b1111, 1);
        chk("clr_err_pulse", 8'(err), 8'd1);
        chk("clr_wins", err_count, 8'd0);
        cyc(1, 4'b1101, 0);

        // Asynchronous reset in mid-cycle while locked
        #3 rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst_locked", 8'(locked), 8'd0);
        chk("async_rst_cnt", err_count, 8'd0);
        @(negedge clk);
        rst = 1'b1;

        // All-zero input never locks
        for (int i = 0; i < 20; i++) cyc(1, 4'b0000, 0);
        chk("zeros_no_lock", 8'(locked), 8'd0);

        // Gapped input: lock still happens on the fifth valid sample
        for (int i = 0; i < 4; i++) begin
            cyc(1, seq[i], 0);
            cyc(0, 4'($urandom_range(0, 15)), 0);
        end
        chk("gap_not_yet", 8'(locked), 8'd0);
        cyc(1, seq[4], 0);
        chk("gap_locked", 8'(locked), 8'd1);

        // Alternate wrong/right samples to drive err_count into saturation
        for (int i = 0; i < 280; i++) begin
            good = seq[(m_idx + 1) % 15];
            cyc(1, good ^ 4'h5, 0);
            good = seq[(m_idx + 1) % 15];
            cyc(1, good, 0);
        end
        chk("sat_cnt", err_count, cnt_exp(300));
        chk("sat_locked", 8'(locked), 8'd1);

        // Random traffic: mostly legal samples, gaps, corruption and clears
        tx = 0;
        for (int i = 0; i < 600; i++) begin
            bit rv, rc;
            logic [3:0] rd;
            rv = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 31) == 0);
            rd = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15)) : seq[tx];
            if (rv) tx = (tx + 1) % 15;
            cyc(rv, rd, rc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lfsr_checker_4bit.md
LFSR_CHECKER_4BIT -- requirements
Module: lfsr_checker_4bit

Interface
REQ-001 Parameter LOCK_CNT, default 4: consecutive correct predictions after seeding that are required to declare lock (range 1..15).
REQ-002 Parameter LOSS_CNT, default 3: consecutive mispredictions while locked that cause loss of lock (range 1..15).
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port data_in, input, 4: received LFSR sample.
REQ-006 Port data_valid, input, 1: data_in is sampled on a rising clk edge when this is high.
REQ-007 Port err_clr, input, 1: synchronous clear of err_count.
REQ-008 Port locked, output, 1: checker is synchronised to the sequence.
REQ-009 Port err, output, 1: one-cycle pulse for each mispredicted sample while locked.
REQ-010 Port err_count, output, 8: saturating count of mispredictions while locked.

Function
REQ-011 The reference sequence SHALL be next = {q[2:0], q[3]^q[2]} (x^4+x^3+1, period 15). 4'b0000 is illegal.
REQ-012 FSM states SHALL be HUNT, VERIFY and LOCKED.
REQ-013 Samples with data_valid low SHALL be ignored: no state, prediction or counter change.
REQ-014 HUNT, valid nonzero sample:
- load the sample as the current state;
- clear the match counter;
- go to VERIFY.
REQ-015 HUNT, valid 4'b0000 sample: ignore it and stay in HUNT.
REQ-016 VERIFY, valid sample equal to the predicted value: increment the match counter and advance the prediction. When the counter reaches LOCK_CNT, go to LOCKED.
REQ-017 VERIFY, valid mismatching sample:
- nonzero: reseed from the sample, reset the match counter, stay in VERIFY;
- zero: go to HUNT.
- err SHALL NOT assert in either case.
REQ-018 LOCKED, valid sample:
- The prediction SHALL always advance from the predicted value (flywheel), never from the sample.
- Match: clear the loss counter.
- Mismatch (including 4'b0000): pulse err, increment err_count, increment the loss counter.
- When the loss counter reaches LOSS_CNT, go to HUNT and clear the loss counter.
REQ-019 locked and err SHALL be registered. Both SHALL change in the cycle after the clock edge that samples the deciding data_in (one-cycle latency).
REQ-020 locked SHALL be high exactly while the state is LOCKED.
REQ-021 err_count SHALL saturate at 255.
REQ-022 err_clr and an error on the same edge: err_clr wins and err_count becomes 0. The err pulse still asserts.
REQ-023 err_count SHALL persist across loss and reacquisition of lock. Only err_clr and reset clear it.

Reset
REQ-024 While rst is low, all outputs and internal state SHALL clear immediately, independent of clk:
- state = HUNT;
- locked = 0, err = 0, err_count = 0;
- prediction, match counter and loss counter = 0.
REQ-025 Reset asserted mid-operation SHALL abandon lock. After release, the checker SHALL reacquire only via HUNT.

Configuration
REQ-026 Macro LFSR_CHK_ERRCNT_EN:
- Defined: err_count and err_clr behave as in REQ-010, REQ-021, REQ-022 and REQ-023.
- Undefined: no counter register is built, err_count is tied to 8'h00 and err_clr is ignored. err and locked are unaffected.

Verification
REQ-027 Lock (valid every cycle): after reset, feed 0001, 0010, 0100, 1001, 0011 -> locked = 1 one cycle after the 0011 edge; err stays 0.
REQ-028 Single error: locked and expecting 0110, feed 1111, then 1101, 1010 -> one err pulse, err_count = 1, locked stays 1, no further err.
REQ-029 Loss: locked, feed three consecutive wrong samples (0000, 0000, 0000) -> three err pulses, err_count = 3, locked = 0 one cycle after the third sample, state HUNT.
REQ-030 Zero and gapped input:
- Feed 0000 repeatedly -> locked never asserts.
- Feed the legal sequence with data_valid low on alternate cycles -> lock at the same sample count as REQ-027.
REQ-031 Reset and clear:
- Assert rst mid-lock between clock edges -> locked = 0 and err_count = 0 immediately.
- err_clr together with an error -> err_count = 0 and err = 1.
- With LFSR_CHK_ERRCNT_EN undefined, rerun REQ-028 -> err pulses, err_count = 0.
